// File: rtl/fp32_divider_if.sv
// fp32_divider_if: start/done handshake, operands, result and status flags of the fp32 divider.
interface fp32_divider_if;
    logic        start_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] quotient_o;
    logic        done_o;
    logic        busy_o;
    logic        nan_o;
    logic        infinit_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        div_by_zero_o;

    modport master (
        output start_i, a_i, b_i,
        input  quotient_o, done_o, busy_o, nan_o, infinit_o, overflow_o, underflow_o, div_by_zero_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output quotient_o, done_o, busy_o, nan_o, infinit_o, overflow_o, underflow_o, div_by_zero_o
    );
endinterface

// File: rtl/fp32_divider.sv
// fp32_divider: sequential IEEE-754 single divider, restoring mantissa divide one quotient bit per cycle,
// round-to-nearest-even, subnormals flushed to zero.
module fp32_divider #(
    parameter logic [31:0] QNAN_VALUE = 32'h7FC00000
) (
    input logic            clk,
    input logic            rst_n,
    fp32_divider_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, PACK, DONE} state_t;

    state_t             r_state, w_next;
    logic [31:0]        r_a, r_b, r_quot;
    logic               r_sign, r_nan, r_inf, r_ovf, r_unf, r_dbz, r_guard, r_sticky;
    logic signed [9:0]  r_exp;
    logic [25:0]        r_q;
    logic [23:0]        r_rem;
    logic [22:0]        r_frac;
    logic [4:0]         r_cnt;

    logic               w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_spec, w_sgn, w_ge0, w_ge, w_rnd;
    logic [23:0]        w_ma, w_mb, w_sum;
    logic [24:0]        w_sh;
    logic signed [9:0]  w_exp_r;

    assign w_za    = r_a[30:23] == 8'd0;
    assign w_zb    = r_b[30:23] == 8'd0;
    assign w_ia    = r_a[30:23] == 8'hFF && r_a[22:0] == 23'd0;
    assign w_ib    = r_b[30:23] == 8'hFF && r_b[22:0] == 23'd0;
    assign w_na    = r_a[30:23] == 8'hFF && r_a[22:0] != 23'd0;
    assign w_nb    = r_b[30:23] == 8'hFF && r_b[22:0] != 23'd0;
    assign w_spec  = w_za | w_zb | (r_a[30:23] == 8'hFF) | (r_b[30:23] == 8'hFF);
    assign w_sgn   = r_a[31] ^ r_b[31];
    assign w_ma    = {1'b1, r_a[22:0]};
    assign w_mb    = {1'b1, r_b[22:0]};
    // The top quotient bit is resolved during UNPACK so DIVIDE needs only 25 more cycles.
    assign w_ge0   = w_ma >= w_mb;
    assign w_sh    = {r_rem, 1'b0};
    assign w_ge    = w_sh >= {1'b0, w_mb};
    assign w_rnd   = r_guard & (r_sticky | r_frac[0]);
    assign w_sum   = {1'b0, r_frac} + {23'd0, w_rnd};
    assign w_exp_r = r_exp + $signed({9'd0, w_sum[23]});

    always_ff @(posedge clk)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_i) w_next = UNPACK;
            UNPACK:  w_next = w_spec ? DONE : DIVIDE;
            DIVIDE:  if (r_cnt == 5'd24) w_next = NORM;
            NORM:    w_next = PACK;
            PACK:    w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.done_o = r_state == DONE;
        bus.busy_o = r_state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_a, r_b, r_quot, r_q, r_rem, r_frac, r_cnt, r_exp} <= '0;
            {r_sign, r_nan, r_inf, r_ovf, r_unf, r_dbz, r_guard, r_sticky} <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start_i) begin
                    r_a <= bus.a_i;
                    r_b <= bus.b_i;
                    {r_nan, r_inf, r_ovf, r_unf, r_dbz} <= '0;
                end
                UNPACK: begin
                    r_sign <= w_sgn;
                    r_exp  <= $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + 10'sd127;
                    r_rem  <= w_ge0 ? w_ma - w_mb : w_ma;
                    r_q    <= {25'd0, w_ge0};
                    r_cnt  <= 5'd0;
                    if (w_na | w_nb | (w_za & w_zb) | (w_ia & w_ib)) begin
                        r_quot <= QNAN_VALUE;
                        r_nan  <= 1'b1;
                    end else if (w_ia) begin
                        r_quot <= {w_sgn, 8'hFF, 23'd0};
                        r_inf  <= 1'b1;
                    end else if (w_zb) begin
                        r_quot <= {w_sgn, 8'hFF, 23'd0};
                        r_inf  <= 1'b1;
                        r_dbz  <= 1'b1;
                    end else if (w_za | w_ib)
                        r_quot <= {w_sgn, 31'd0};
                end
                DIVIDE: begin
                    r_rem <= w_ge ? 24'(w_sh - {1'b0, w_mb}) : w_sh[23:0];
                    r_q   <= {r_q[24:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                NORM: begin
                    r_frac   <= r_q[25] ? r_q[24:2] : r_q[23:1];
                    r_guard  <= r_q[25] ? r_q[1] : r_q[0];
                    r_sticky <= (r_q[25] & r_q[0]) | (|r_rem);
                    if (!r_q[25]) r_exp <= r_exp - 10'sd1;
                end
                PACK: begin
                    if (w_exp_r >= 10'sd255) begin
                        r_quot <= {r_sign, 8'hFF, 23'd0};
                        r_ovf  <= 1'b1;
                        r_inf  <= 1'b1;
                    end else if (w_exp_r <= 10'sd0) begin
                        r_quot <= {r_sign, 31'd0};
                        r_unf  <= 1'b1;
                    end else
                        r_quot <= {r_sign, w_exp_r[7:0], w_sum[22:0]};
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient_o    = r_quot;
    assign bus.nan_o         = r_nan;
    assign bus.infinit_o     = r_inf;
    assign bus.overflow_o    = r_ovf;
    assign bus.underflow_o   = r_unf;
    assign bus.div_by_zero_o = r_dbz;
endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: directed and random divides checked against an integer-arithmetic IEEE model.
module tb_fp32_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [4:0] w_flags;

    fp32_divider_if bus();
    fp32_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign w_flags = {bus.nan_o, bus.infinit_o, bus.overflow_o, bus.underflow_o, bus.div_by_zero_o};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact quotient via wide integer division, then IEEE round-to-nearest-even.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [4:0] f, output int lat);
        int ea, eb, e, sh;
        bit an, bn, ai, bi, az, bz, s, up;
        longint unsigned ma, mb, qq, rr, m, rest, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = ea == 255 && a[22:0] != 0;
        bn = eb == 255 && b[22:0] != 0;
        ai = ea == 255 && a[22:0] == 0;
        bi = eb == 255 && b[22:0] == 0;
        az = ea == 0;
        bz = eb == 0;
        s  = a[31] ^ b[31];
        f  = 5'b00000;
        lat = 2;
        if (an || bn || (az && bz) || (ai && bi)) begin
            q = 32'h7FC00000; f = 5'b10000;
        end else if (ai) begin
            q = {s, 8'hFF, 23'd0}; f = 5'b01000;
        end else if (bz) begin
            q = {s, 8'hFF, 23'd0}; f = 5'b01001;
        end else if (az || bi) begin
            q = {s, 31'd0};
        end else begin
            lat = 29;
            ma = 64'(8388608 + int'(a[22:0]));
            mb = 64'(8388608 + int'(b[22:0]));
            qq = (ma << 38) / mb;
            rr = (ma << 38) % mb;
            e  = ea - eb + 127;
            sh = (qq >= (64'd1 << 38)) ? 15 : 14;
            if (sh == 14) e--;
            m    = qq >> sh;
            rest = qq & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            up   = rest > half || (rest == half && (rr != 0 || m[0]));
            if (up) m++;
            if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e++; end
            if (e >= 255) begin
                q = {s, 8'hFF, 23'd0}; f = 5'b01100;
            end else if (e <= 0) begin
                q = {s, 31'd0}; f = 5'b00010;
            end else
                q = {s, e[7:0], m[22:0]};
        end
    endfunction

    task automatic run(input logic [31:0] a, input logic [31:0] b, output int lat, output bit bok);
        bus.a_i = a;
        bus.b_i = b;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = 1;
        bok = bus.busy_o;
        while (!bus.done_o && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            bok &= bus.busy_o;
        end
    endtask

    task automatic check(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [4:0]  f;
        int          elat, lat;
        bit          bok;
        model(a, b, q, f, elat);
        run(a, b, lat, bok);
        chk($sformatf("quot %h/%h", a, b), 64'(bus.quotient_o), 64'(q));
        chk($sformatf("flags %h/%h", a, b), 64'(w_flags), 64'(f));
        chk($sformatf("lat %h/%h", a, b), 64'(lat), 64'(elat));
        chk("busy", 64'(bok), 64'd1);
        @(posedge clk); #1;
        chk("hold", {bus.quotient_o, w_flags, bus.done_o, bus.busy_o}, {q, f, 2'b00});
    endtask

    initial begin
        int n, seen;
        logic [31:0] a, b;
        bus.start_i = 1'b0;
        bus.a_i = '0;
        bus.b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {bus.quotient_o, w_flags, bus.done_o, bus.busy_o}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        check(32'h41200000, 32'h40800000);
        check(32'h414147AE, 32'h40800000);
        check(32'h3F800000, 32'h40400000);
        check(32'hC0400000, 32'h40000000);
        check(32'h3F800000, 32'h00000000);
        check(32'h00000000, 32'h00000000);
        check(32'h7F800001, 32'h3F800000);
        check(32'h7F7FFFFF, 32'h00800000);
        check(32'h00800000, 32'h7F7FFFFF);
        check(32'h00000001, 32'h3F800000);
        check(32'hFF800000, 32'h7F800000);
        check(32'h7F800000, 32'hC0000000);
        check(32'h80000000, 32'hFF800000);

        bus.a_i = 32'h41200000;
        bus.b_i = 32'h40800000;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        n = 1;
        while (n < 10) begin @(posedge clk); #1; n++; end
        bus.a_i = 32'h3F800000;
        bus.b_i = 32'h40400000;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        n++;
        bus.start_i = 1'b0;
        while (!bus.done_o && n < 60) begin @(posedge clk); #1; n++; end
        chk("ign_lat", 64'(n), 64'd29);
        chk("ign_quot", 64'(bus.quotient_o), 64'h40200000);
        @(posedge clk); #1;

        bus.a_i = 32'h41200000;
        bus.b_i = 32'h40800000;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        n = 1;
        while (n < 15) begin @(posedge clk); #1; n++; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst", {bus.quotient_o, w_flags, bus.done_o, bus.busy_o}, 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (35) begin @(posedge clk); #1; if (bus.done_o || bus.busy_o) seen++; end
        chk("rst_nodone", 64'(seen), 64'd0);
        check(32'h41200000, 32'h40800000);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    if ($urandom_range(0, 1) == 1) a[30:23] = $urandom_range(0, 1) == 1 ? 8'hFF : 8'h00;
                    else                           b[30:23] = $urandom_range(0, 1) == 1 ? 8'hFF : 8'h00;
                    if ($urandom_range(0, 1) == 1) begin a[22:0] = '0; b[22:0] = '0; end
                end
                1: begin
                    a[30:23] = 8'($urandom_range(190, 254));
                    b[30:23] = 8'($urandom_range(1, 66));
                    if ($urandom_range(0, 1) == 1) begin
                        a[30:23] = 8'($urandom_range(1, 66));
                        b[30:23] = 8'($urandom_range(190, 254));
                    end
                end
                default: begin
                    a[30:23] = 8'($urandom_range(1, 254));
                    b[30:23] = 8'($urandom_range(1, 254));
                end
            endcase
            check(a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
